// File: rtl/axis_frame_capture_if.sv
// AXI4-Stream beat bus into the frame capture buffer.
// The master drives data, valid and last; the slave returns ready.
interface axis_frame_capture_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] tdata;
   logic             tvalid;
   logic             tlast;
   logic             tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_frame_capture.sv
// Captures FRAMES tlast-aligned frames of FFT_LEN beats into block RAM.
// Supports an optional frame skip, sticky framing-error reporting and a registered read port.
module axis_frame_capture #(
   parameter int WIDTH    = 32,
   parameter int FFT_LEN  = 64,
   parameter int FRAMES   = 32,
   parameter int CONF_WID = 8,
   parameter int BP_FULL  = 0,
   localparam int DEPTH   = FRAMES * FFT_LEN,
   localparam int AW      = $clog2(DEPTH),
   localparam int FW      = $clog2(FRAMES + 1),
   localparam int BW      = $clog2(FFT_LEN)
) (
   input  logic                clk,
   input  logic                rst_n,
   axis_frame_capture_if.slave s_axis,
   input  logic                arm,
   input  logic [CONF_WID-1:0] skip_frames,
   output logic                capturing,
   output logic                full,
   output logic                tlast_err,
   output logic [FW-1:0]       frames_done,
   input  logic                rd_en,
   input  logic [AW-1:0]       rd_addr,
   output logic [WIDTH-1:0]    rd_data
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ARMED   = 3'd1;
   localparam logic [2:0] ST_SKIP    = 3'd2;
   localparam logic [2:0] ST_CAPTURE = 3'd3;
   localparam logic [2:0] ST_FULL    = 3'd4;

   localparam logic [BW-1:0] LAST_BEAT = BW'(FFT_LEN - 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   logic [2:0]          state;
   logic [AW-1:0]       wr_addr;
   logic [BW-1:0]       beat_cnt;
   logic [CONF_WID-1:0] skip_cnt;
   logic [WIDTH-1:0]    ram [DEPTH];

   logic hs;
   logic hs_last;
   logic checking;
   logic wr_en;

   assign s_axis.tready = !((BP_FULL != 0) && (state == ST_FULL));
   assign hs            = s_axis.tvalid & s_axis.tready;
   assign hs_last       = hs & s_axis.tlast;
   assign checking      = (state == ST_SKIP) || (state == ST_CAPTURE);
   assign capturing     = checking;
   assign full          = (state == ST_FULL);
   // arm takes priority over a write landing in the same cycle
   assign wr_en         = hs && (state == ST_CAPTURE) && !arm;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         wr_addr     <= '0;
         beat_cnt    <= '0;
         skip_cnt    <= '0;
         frames_done <= '0;
         tlast_err   <= 1'b0;
      end else if (arm) begin
         state       <= ST_ARMED;
         wr_addr     <= '0;
         beat_cnt    <= '0;
         frames_done <= '0;
         tlast_err   <= 1'b0;
         skip_cnt    <= skip_frames;
      end else begin
         case (state)
            ST_ARMED: begin
               if (hs_last) state <= (skip_cnt != '0) ? ST_SKIP : ST_CAPTURE;
            end
            ST_SKIP: begin
               if (hs_last) begin
                  skip_cnt <= skip_cnt - 1'b1;
                  if (skip_cnt == CONF_WID'(1)) state <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (hs) begin
                  wr_addr <= wr_addr + 1'b1;
                  if (s_axis.tlast) frames_done <= frames_done + 1'b1;
                  if (wr_addr == LAST_ADDR) state <= ST_FULL;
               end
            end
            default: ;
         endcase

         // beat_cnt follows the stream's own tlast so a single bad frame does not cascade
         if (checking && hs) begin
            beat_cnt <= s_axis.tlast ? '0 : beat_cnt + 1'b1;
            if (s_axis.tlast != (beat_cnt == LAST_BEAT)) tlast_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) ram[wr_addr] <= s_axis.tdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= ram[rd_addr];
      end
   end

endmodule

// File: tb/tb_axis_frame_capture.sv
// Directed bench for axis_frame_capture: one instance with BP_FULL=0 and one with BP_FULL=1
// share the same ramp stream, arm, and read controls.
module tb_axis_frame_capture;

   localparam int WIDTH    = 32;
   localparam int FFT_LEN  = 8;
   localparam int FRAMES   = 2;
   localparam int CONF_WID = 8;
   localparam int AW       = 4;
   localparam int FW       = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [WIDTH-1:0]    tdata;
   logic                tvalid;
   logic                tlast;
   logic                arm;
   logic [CONF_WID-1:0] skip_frames;
   logic                rd_en;
   logic [AW-1:0]       rd_addr;

   logic             capturing0, full0, err0, capturing1, full1, err1;
   logic [FW-1:0]    frames0, frames1;
   logic [WIDTH-1:0] rd_data0, rd_data1;

   axis_frame_capture_if #(.WIDTH(WIDTH)) bus0 ();
   axis_frame_capture_if #(.WIDTH(WIDTH)) bus1 ();

   assign bus0.tdata  = tdata;
   assign bus0.tvalid = tvalid;
   assign bus0.tlast  = tlast;
   assign bus1.tdata  = tdata;
   assign bus1.tvalid = tvalid;
   assign bus1.tlast  = tlast;

   axis_frame_capture #(
      .WIDTH(WIDTH), .FFT_LEN(FFT_LEN), .FRAMES(FRAMES), .CONF_WID(CONF_WID), .BP_FULL(0)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .s_axis(bus0), .arm(arm), .skip_frames(skip_frames),
      .capturing(capturing0), .full(full0), .tlast_err(err0), .frames_done(frames0),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0)
   );

   axis_frame_capture #(
      .WIDTH(WIDTH), .FFT_LEN(FFT_LEN), .FRAMES(FRAMES), .CONF_WID(CONF_WID), .BP_FULL(1)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .s_axis(bus1), .arm(arm), .skip_frames(skip_frames),
      .capturing(capturing1), .full(full1), .tlast_err(err1), .frames_done(frames1),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   int beat_val     = 0;
   int bad_last     = -1;
   int skip_last    = -1;

   // Present one cycle of stream; the ramp value and tlast pattern come from beat_val
   task automatic cycle(input logic v);
      tvalid = v;
      tdata  = WIDTH'(beat_val);
      tlast  = (((beat_val % FFT_LEN) == FFT_LEN - 1) && (beat_val != skip_last)) ||
               (beat_val == bad_last);
      @(posedge clk);
      #1;
      if (v) beat_val++;
      arm    = 1'b0;
      tvalid = 1'b0;
      tlast  = 1'b0;
   endtask

   task automatic run_to(input int target);
      for (int g = 0; g < 400 && beat_val < target; g++) cycle(1'b1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      arm = 1'b0; tvalid = 1'b0; rd_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      beat_val = 0; bad_last = -1; skip_last = -1;
   endtask

   task automatic start_capture(input logic [CONF_WID-1:0] skip);
      skip_frames = skip;
      repeat (3) cycle(1'b1);
      arm = 1'b1;
      cycle(1'b1);
   endtask

   task automatic read_check(input int base);
      tvalid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         rd_en = 1'b1; rd_addr = AW'(i);
         @(posedge clk);
         #1;
         tests_run++;
         if (rd_data0 !== WIDTH'(base + i)) begin tests_failed++; $display("[TB] FAIL read0[%0d] got %0d want %0d", i, rd_data0, base + i); end
         tests_run++;
         if (rd_data1 !== WIDTH'(base + i)) begin tests_failed++; $display("[TB] FAIL read1[%0d] got %0d want %0d", i, rd_data1, base + i); end
      end
      rd_en = 1'b0; rd_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (rd_data0 !== WIDTH'(base + 15)) begin tests_failed++; $display("[TB] FAIL read_hold got %0d want %0d", rd_data0, base + 15); end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      tests_run++; if (bus0.tready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_tready0 got %b want 1", bus0.tready); end
      tests_run++; if (bus1.tready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_tready1 got %b want 1", bus1.tready); end
      tests_run++; if (capturing0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_capturing got %b want 0", capturing0); end
      tests_run++; if (full0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_full got %b want 0", full0); end
      tests_run++; if (err0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err got %b want 0", err0); end
      tests_run++; if (frames0 !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_frames got %0d want 0", frames0); end
      tests_run++; if (rd_data0 !== '0) begin tests_failed++; $display("[TB] FAIL reset_rd_data got %0d want 0", rd_data0); end
      do_reset();
   endtask

   task automatic test_ramp_capture();
      do_reset();
      start_capture(8'd0);
      run_to(7);
      tests_run++; if (capturing0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL ramp_armed_capturing got %b want 0", capturing0); end
      cycle(1'b1);
      tests_run++; if (capturing0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL ramp_capturing_rise got %b want 1", capturing0); end
      run_to(23);
      tests_run++; if (full0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL ramp_full_early got %b want 0", full0); end
      tests_run++; if (frames0 !== 2'd1) begin tests_failed++; $display("[TB] FAIL ramp_frames_mid got %0d want 1", frames0); end
      cycle(1'b1);
      tests_run++; if (full0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL ramp_full got %b want 1", full0); end
      tests_run++; if (capturing0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL ramp_capturing_fall got %b want 0", capturing0); end
      tests_run++; if (frames0 !== 2'd2) begin tests_failed++; $display("[TB] FAIL ramp_frames got %0d want 2", frames0); end
      tests_run++; if (err0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL ramp_err got %b want 0", err0); end
      tests_run++; if (bus0.tready !== 1'b1) begin tests_failed++; $display("[TB] FAIL ramp_tready0 got %b want 1", bus0.tready); end
      tests_run++; if (bus1.tready !== 1'b0) begin tests_failed++; $display("[TB] FAIL ramp_tready1 got %b want 0", bus1.tready); end
      read_check(8);
   endtask

   task automatic test_frame_skip();
      do_reset();
      start_capture(8'd3);
      run_to(20);
      tests_run++; if (capturing0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL skip_capturing got %b want 1", capturing0); end
      run_to(32);
      tests_run++; if (frames0 !== 2'd0) begin tests_failed++; $display("[TB] FAIL skip_frames_pre got %0d want 0", frames0); end
      run_to(40);
      tests_run++; if (frames0 !== 2'd1) begin tests_failed++; $display("[TB] FAIL skip_frames_mid got %0d want 1", frames0); end
      run_to(47);
      tests_run++; if (full0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL skip_full_early got %b want 0", full0); end
      cycle(1'b1);
      tests_run++; if (full0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL skip_full got %b want 1", full0); end
      read_check(32);
      skip_frames = '0;
   endtask

   task automatic test_framing_error();
      do_reset();
      bad_last = 12; skip_last = 15;
      start_capture(8'd0);
      run_to(12);
      tests_run++; if (err0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL ferr_before got %b want 0", err0); end
      cycle(1'b1);
      tests_run++; if (err0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL ferr_set got %b want 1", err0); end
      run_to(24);
      tests_run++; if (full0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL ferr_full got %b want 1", full0); end
      tests_run++; if (err0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL ferr_sticky got %b want 1", err0); end
      tests_run++; if (frames0 !== 2'd2) begin tests_failed++; $display("[TB] FAIL ferr_frames got %0d want 2", frames0); end
      read_check(8);
      bad_last = -1; skip_last = -1;
   endtask

   task automatic test_back_to_back();
      bit stalled = 1'b0;
      do_reset();
      arm = 1'b1;
      cycle(1'b1);
      for (int g = 0; g < 400 && beat_val < 24; g++) begin
         cycle(1'($urandom_range(0, 1)));
         if (!full1 && bus1.tready !== 1'b1) stalled = 1'b1;
      end
      tests_run++; if (full1 !== 1'b1) begin tests_failed++; $display("[TB] FAIL gaps_full got %b want 1", full1); end
      tests_run++; if (stalled !== 1'b0) begin tests_failed++; $display("[TB] FAIL gaps_tready_drop got %b want 0", stalled); end
      tests_run++; if (bus1.tready !== 1'b0) begin tests_failed++; $display("[TB] FAIL gaps_bp_tready got %b want 0", bus1.tready); end
      tests_run++; if (frames1 !== 2'd2) begin tests_failed++; $display("[TB] FAIL gaps_frames got %0d want 2", frames1); end
      read_check(8);
      arm = 1'b1;
      cycle(1'b0);
      tests_run++; if (bus1.tready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rearm_tready got %b want 1", bus1.tready); end
      tests_run++; if (full1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL rearm_full got %b want 0", full1); end
      tests_run++; if (frames1 !== 2'd0) begin tests_failed++; $display("[TB] FAIL rearm_frames got %0d want 0", frames1); end
   endtask

   task automatic test_arm_mid_capture();
      do_reset();
      start_capture(8'd0);
      run_to(13);
      tests_run++; if (capturing0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_capturing got %b want 1", capturing0); end
      arm = 1'b1;
      cycle(1'b1);
      tests_run++; if (capturing0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rearmed got %b want 0", capturing0); end
      tests_run++; if (frames0 !== 2'd0) begin tests_failed++; $display("[TB] FAIL mid_frames_clr got %0d want 0", frames0); end
      run_to(24);
      tests_run++; if (frames0 !== 2'd1) begin tests_failed++; $display("[TB] FAIL mid_frames got %0d want 1", frames0); end
      tests_run++; if (full0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_full_early got %b want 0", full0); end
      run_to(32);
      tests_run++; if (full0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_full got %b want 1", full0); end
      read_check(16);
   endtask

   task automatic test_async_reset();
      bad_last = 44;
      arm = 1'b1;
      cycle(1'b1);
      run_to(45);
      tests_run++; if (err0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL areset_err_pre got %b want 1", err0); end
      tests_run++; if (frames0 !== 2'd1) begin tests_failed++; $display("[TB] FAIL areset_frames_pre got %0d want 1", frames0); end
      cycle(1'b1);
      rst_n = 1'b0;
      #2;
      tests_run++; if (capturing0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL areset_capturing got %b want 0", capturing0); end
      tests_run++; if (err0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL areset_err got %b want 0", err0); end
      tests_run++; if (frames0 !== 2'd0) begin tests_failed++; $display("[TB] FAIL areset_frames got %0d want 0", frames0); end
      tests_run++; if (rd_data0 !== '0) begin tests_failed++; $display("[TB] FAIL areset_rd_data got %0d want 0", rd_data0); end
      tests_run++; if (full0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL areset_full got %b want 0", full0); end
      tests_run++; if (bus1.tready !== 1'b1) begin tests_failed++; $display("[TB] FAIL areset_tready got %b want 1", bus1.tready); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bad_last = -1;
      beat_val = 0;
      run_to(20);
      tests_run++; if (capturing0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_capturing got %b want 0", capturing0); end
      tests_run++; if (frames0 !== 2'd0) begin tests_failed++; $display("[TB] FAIL idle_frames got %0d want 0", frames0); end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      tdata = '0; tvalid = 1'b0; tlast = 1'b0; arm = 1'b0;
      skip_frames = '0; rd_en = 1'b0; rd_addr = '0;
      test_reset();
      test_ramp_capture();
      test_frame_skip();
      test_framing_error();
      test_back_to_back();
      test_arm_mid_capture();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
